// File: rtl/cache_mem_arbiter.sv
// Shares one lower-memory port between I-cache and D-cache miss paths (optional WB, then FILL).
// Define ARB_DCACHE_PRIO_EN for fixed D-cache priority on ties; default is round-robin.
module cache_mem_arbiter #(
    parameter int BLOCK_SIZE = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_req,
    input  logic                     i_wb,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [ADDR_W-1:0]        i_wb_addr,
    input  logic [BLOCK_SIZE*32-1:0] i_wb_data,
    output logic                     i_done,
    output logic [BLOCK_SIZE*32-1:0] i_rdata,
    input  logic                     d_req,
    input  logic                     d_wb,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [ADDR_W-1:0]        d_wb_addr,
    input  logic [BLOCK_SIZE*32-1:0] d_wb_data,
    output logic                     d_done,
    output logic [BLOCK_SIZE*32-1:0] d_rdata,
    output logic                     mem_valid,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BLOCK_SIZE*32-1:0] mem_wdata,
    input  logic                     mem_ready,
    input  logic [BLOCK_SIZE*32-1:0] mem_rdata,
    output logic                     grant_d,
    output logic                     busy
);

    localparam int BW  = BLOCK_SIZE * 32;
    localparam int OFF = $clog2(BW / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W)'((1 << OFF) - 1));

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t            state;
    logic              cur_d;
    logic [ADDR_W-1:0] fill_addr;
    logic              pick_d;
    logic              pick_wb;
    logic [ADDR_W-1:0] pick_addr;
    logic [ADDR_W-1:0] pick_wb_addr;
    logic [BW-1:0]     pick_wb_data;

`ifndef ARB_DCACHE_PRIO_EN
    logic last_grant_d;
`endif

    // A sole requester always wins; a tie goes to D under fixed priority, else to the port not served last.
    always_comb begin
        pick_d = 1'b0;
`ifdef ARB_DCACHE_PRIO_EN
        pick_d = d_req;
`else
        pick_d = d_req && (!i_req || !last_grant_d);
`endif
        pick_wb      = pick_d ? d_wb      : i_wb;
        pick_addr    = pick_d ? d_addr    : i_addr;
        pick_wb_addr = pick_d ? d_wb_addr : i_wb_addr;
        pick_wb_data = pick_d ? d_wb_data : i_wb_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur_d     <= 1'b0;
            fill_addr <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_d   <= 1'b0;
            busy      <= 1'b0;
`ifndef ARB_DCACHE_PRIO_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        cur_d     <= pick_d;
                        grant_d   <= pick_d;
                        busy      <= 1'b1;
                        mem_valid <= 1'b1;
                        fill_addr <= pick_addr & ALIGN_MASK;
                        if (pick_wb) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= pick_wb_addr & ALIGN_MASK;
                            mem_wdata <= pick_wb_data;
                        end else begin
                            state     <= FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= pick_addr & ALIGN_MASK;
                            mem_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        state     <= FILL;
                        mem_we    <= 1'b0;
                        mem_addr  <= fill_addr;
                        mem_wdata <= '0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        if (cur_d) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end
`ifndef ARB_DCACHE_PRIO_EN
                        last_grant_d <= cur_d;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    grant_d <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
